// File: rtl/daq_pkg.sv
// Shared state encoding, sequencing constants and helpers for the DAQ acquisition sequencer.
package daq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADC_RST,
    WAIT_TICK,
    CONVST,
    WAIT_BUSY_H,
    WAIT_BUSY_L,
    RD_LOW,
    RD_HIGH,
    DONE
  } state_e;

  localparam int ADC_RST_CYC = 4;
  localparam int BUSY_H_TMO  = 16;
  localparam int BUSY_L_TMO  = 65535;
  localparam int PERIOD_MIN  = 2;
  localparam int TMR_W       = 16;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/daq_tick_gen.sv
// Conversion period timer: down-counter that ticks at a count of 1 and reloads from period_i.
module daq_tick_gen
  import daq_pkg::*;
#(
  parameter int PERIOD_W = 24
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic                load_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tick_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] reload;

  always_comb begin
    reload = (period_i < PERIOD_W'(PERIOD_MIN)) ? PERIOD_W'(PERIOD_MIN) : period_i;
    tick_o = en_i && !load_i && (cnt_q == PERIOD_W'(1));
    cnt_d  = cnt_q;
    if (load_i) begin
      cnt_d = reload;
    end else if (en_i) begin
      // a count of 0 only exists before the first load; treat it as terminal so it cannot stick
      cnt_d = (cnt_q <= PERIOD_W'(1)) ? reload : cnt_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/daq_acq_sequencer.sv
// Sequences the simultaneous-sampling ADC: periodic convert, BUSY handshake, parallel read of all channels.
//   state       | meaning
//   IDLE        | acquisition off, ADC pins parked
//   ADC_RST     | adc_reset_o pulse, period timer loaded on exit
//   WAIT_TICK   | waiting for a period tick (drop when FIFO almost full)
//   CONVST      | convst held low
//   WAIT_BUSY_H | waiting for BUSY to rise
//   WAIT_BUSY_L | waiting for BUSY to fall
//   RD_LOW      | cs/rd low, data captured on last cycle
//   RD_HIGH     | rd high between channels
//   DONE        | frame complete, cs released
module daq_acq_sequencer
  import daq_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int DW       = 16,
  parameter int PERIOD_W = 24,
  parameter int CONVST_W = 4,
  parameter int RD_LO    = 4,
  parameter int RD_HI    = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [2:0]          os_sel_i,
  input  logic                fifo_afull_i,
  input  logic                adc_busy_i,
  input  logic [DW-1:0]       adc_db_i,
  output logic [2:0]          adc_os_o,
  output logic                adc_reset_o,
  output logic                adc_convst_o,
  output logic                adc_cs_o,
  output logic                adc_rd_o,
  output logic [DW-1:0]       sample_o,
  output logic [2:0]          sample_ch_o,
  output logic                sample_valid_o,
  output logic                frame_start_o,
  output logic [15:0]         frame_cnt_o,
  output logic [15:0]         drop_cnt_o,
  output logic [15:0]         overrun_cnt_o,
  output logic                timeout_o
);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [2:0]         ch_q, ch_d;
  logic [2:0]         os_q, os_d;
  logic               convst_q, convst_d;
  logic               cs_q, cs_d;
  logic               rd_q, rd_d;
  logic               adc_rst_q, adc_rst_d;
  logic [DW-1:0]      sample_q, sample_d;
  logic [2:0]         sample_ch_q, sample_ch_d;
  logic               valid_q, valid_d;
  logic               fstart_q, fstart_d;
  logic [15:0]        frame_q, frame_d;
  logic [15:0]        drop_q, drop_d;
  logic [15:0]        ovr_q, ovr_d;
  logic               tmo_q, tmo_d;
  logic               tick;
  logic               tick_en;
  logic               tick_load;

  assign tick_en = (state_q != IDLE) && (state_q != ADC_RST);

  daq_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick_gen (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (tick_en),
    .load_i   (tick_load),
    .period_i (period_i),
    .tick_o   (tick)
  );

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    ch_d        = ch_q;
    os_d        = os_q;
    sample_d    = sample_q;
    sample_ch_d = sample_ch_q;
    valid_d     = 1'b0;
    fstart_d    = 1'b0;
    frame_d     = frame_q;
    drop_d      = drop_q;
    ovr_d       = ovr_q;
    tmo_d       = tmo_q;
    tick_load   = 1'b0;

    // ticks are never queued: one landing outside WAIT_TICK is only counted
    if (tick && (state_q != WAIT_TICK)) ovr_d = sat_inc16(ovr_q);

    case (state_q)
      IDLE: begin
        if (en_i) begin
          os_d    = os_sel_i;
          frame_d = '0;
          drop_d  = '0;
          ovr_d   = '0;
          tmo_d   = 1'b0;
          tmr_d   = TMR_W'(ADC_RST_CYC);
          state_d = ADC_RST;
        end
      end
      ADC_RST: begin
        if (tmr_q == TMR_W'(1)) begin
          tick_load = 1'b1;
          state_d   = WAIT_TICK;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      WAIT_TICK: begin
        if (!en_i) begin
          state_d = IDLE;
        end else if (tick) begin
          if (fifo_afull_i) begin
            drop_d = sat_inc16(drop_q);
          end else begin
            tmr_d   = TMR_W'(CONVST_W);
            state_d = CONVST;
          end
        end
      end
      CONVST: begin
        if (tmr_q == TMR_W'(1)) begin
          tmr_d   = TMR_W'(BUSY_H_TMO);
          state_d = WAIT_BUSY_H;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      WAIT_BUSY_H: begin
        if (adc_busy_i) begin
          tmr_d   = TMR_W'(BUSY_L_TMO);
          state_d = WAIT_BUSY_L;
        end else if (tmr_q == TMR_W'(1)) begin
          tmo_d   = 1'b1;
          state_d = WAIT_TICK;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      WAIT_BUSY_L: begin
        if (!adc_busy_i) begin
          ch_d    = '0;
          tmr_d   = TMR_W'(RD_LO);
          state_d = RD_LOW;
        end else if (tmr_q == TMR_W'(1)) begin
          tmo_d   = 1'b1;
          state_d = WAIT_TICK;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      RD_LOW: begin
        if (tmr_q == TMR_W'(1)) begin
          sample_d    = adc_db_i;
          sample_ch_d = ch_q;
          valid_d     = 1'b1;
          fstart_d    = (ch_q == 3'd0);
          tmr_d       = TMR_W'(RD_HI);
          state_d     = RD_HIGH;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      RD_HIGH: begin
        if (tmr_q == TMR_W'(1)) begin
          if (ch_q == 3'(NUM_CH - 1)) begin
            state_d = DONE;
          end else begin
            ch_d    = ch_q + 3'd1;
            tmr_d   = TMR_W'(RD_LO);
            state_d = RD_LOW;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      DONE: begin
        frame_d = frame_q + 16'd1;
        state_d = en_i ? WAIT_TICK : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // ADC pins are registered decodes of the next state so they never glitch
    adc_rst_d = (state_d == ADC_RST);
    convst_d  = (state_d != CONVST);
    cs_d      = !((state_d == RD_LOW) || (state_d == RD_HIGH));
    rd_d      = (state_d != RD_LOW);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      ch_q        <= '0;
      os_q        <= '0;
      convst_q    <= 1'b1;
      cs_q        <= 1'b1;
      rd_q        <= 1'b1;
      adc_rst_q   <= 1'b0;
      sample_q    <= '0;
      sample_ch_q <= '0;
      valid_q     <= 1'b0;
      fstart_q    <= 1'b0;
      frame_q     <= '0;
      drop_q      <= '0;
      ovr_q       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      ch_q        <= ch_d;
      os_q        <= os_d;
      convst_q    <= convst_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      adc_rst_q   <= adc_rst_d;
      sample_q    <= sample_d;
      sample_ch_q <= sample_ch_d;
      valid_q     <= valid_d;
      fstart_q    <= fstart_d;
      frame_q     <= frame_d;
      drop_q      <= drop_d;
      ovr_q       <= ovr_d;
      tmo_q       <= tmo_d;
    end
  end

  assign adc_os_o       = os_q;
  assign adc_reset_o    = adc_rst_q;
  assign adc_convst_o   = convst_q;
  assign adc_cs_o       = cs_q;
  assign adc_rd_o       = rd_q;
  assign sample_o       = sample_q;
  assign sample_ch_o    = sample_ch_q;
  assign sample_valid_o = valid_q;
  assign frame_start_o  = fstart_q;
  assign frame_cnt_o    = frame_q;
  assign drop_cnt_o     = drop_q;
  assign overrun_cnt_o  = ovr_q;
  assign timeout_o      = tmo_q;

endmodule

// File: tb/tb_daq_acq_sequencer.sv
// Bench for daq_acq_sequencer: behavioural ADC model feeding a sample scoreboard plus counter checks.
module tb_daq_acq_sequencer;

  localparam int DW       = 16;
  localparam int PERIOD_W = 24;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic                en_i;
  logic [PERIOD_W-1:0] period_i;
  logic [2:0]          os_sel_i;
  logic                fifo_afull_i;
  logic                adc_busy_i;
  logic [DW-1:0]       adc_db_i;
  logic [2:0]          adc_os_o;
  logic                adc_reset_o;
  logic                adc_convst_o;
  logic                adc_cs_o;
  logic                adc_rd_o;
  logic [DW-1:0]       sample_o;
  logic [2:0]          sample_ch_o;
  logic                sample_valid_o;
  logic                frame_start_o;
  logic [15:0]         frame_cnt_o;
  logic [15:0]         drop_cnt_o;
  logic [15:0]         overrun_cnt_o;
  logic                timeout_o;

  daq_acq_sequencer dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .en_i           (en_i),
    .period_i       (period_i),
    .os_sel_i       (os_sel_i),
    .fifo_afull_i   (fifo_afull_i),
    .adc_busy_i     (adc_busy_i),
    .adc_db_i       (adc_db_i),
    .adc_os_o       (adc_os_o),
    .adc_reset_o    (adc_reset_o),
    .adc_convst_o   (adc_convst_o),
    .adc_cs_o       (adc_cs_o),
    .adc_rd_o       (adc_rd_o),
    .sample_o       (sample_o),
    .sample_ch_o    (sample_ch_o),
    .sample_valid_o (sample_valid_o),
    .frame_start_o  (frame_start_o),
    .frame_cnt_o    (frame_cnt_o),
    .drop_cnt_o     (drop_cnt_o),
    .overrun_cnt_o  (overrun_cnt_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [2:0]  ch;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  // ADC model: BUSY 2 cycles after convst rises, 20 cycles long; data = base + read index
  bit          busy_en       = 1'b1;
  logic [15:0] data_base     = 16'h1000;
  int          busy_dly      = 0;
  int          busy_hold     = 0;
  int          rd_idx        = 0;
  int          convst_falls  = 0;
  int          last_rise_cyc = 0;
  logic        convst_prev   = 1'b1;
  logic        rd_prev       = 1'b1;

  initial begin
    exp_t e;
    adc_busy_i = 1'b0;
    adc_db_i   = '0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        busy_dly   = 0;
        busy_hold  = 0;
        rd_idx     = 0;
        adc_busy_i = 1'b0;
      end else begin
        if (busy_hold > 0) begin
          busy_hold--;
          if (busy_hold == 0) adc_busy_i = 1'b0;
        end
        if (busy_dly > 0) begin
          busy_dly--;
          if (busy_dly == 0) begin
            adc_busy_i = 1'b1;
            busy_hold  = 20;
          end
        end
        if (!convst_prev && adc_convst_o) begin
          last_rise_cyc = cyc;
          if (busy_en) begin
            busy_dly = 1;
            for (int c = 0; c < 8; c++) begin
              e.ch   = 3'(c);
              e.data = data_base + 16'(c);
              exp_q.push_back(e);
            end
          end
        end
        if (convst_prev && !adc_convst_o) convst_falls++;
        if (adc_cs_o) rd_idx = 0;
        else if (rd_prev && !adc_rd_o) begin
          adc_db_i = data_base + 16'(rd_idx);
          rd_idx++;
        end
      end
      convst_prev = adc_convst_o;
      rd_prev     = adc_rd_o;
    end
  end

  int n_samp     = 0;
  int last_v_cyc = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sample_valid_o) begin
        n_samp++;
        chk_eq("sb_empty_on_sample", 32'(exp_q.size() == 0), 32'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk_eq("sample_data", sample_o, e.data);
          chk_eq("sample_ch", sample_ch_o, e.ch);
          chk_eq("frame_start", frame_start_o, e.ch == 3'd0);
          if (e.ch != 3'd0) chk_eq("sample_spacing", cyc - last_v_cyc, 6);
        end
        last_v_cyc = cyc;
      end else if (frame_start_o) begin
        chk_eq("frame_start_stray", frame_start_o, 1'b0);
      end
    end
  end

  task automatic wait_frames(input int n, input int budget, input string tag);
    logic [15:0] tgt;
    int i;
    tgt = frame_cnt_o + 16'(n);
    i = 0;
    while (frame_cnt_o != tgt && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    chk_eq(tag, frame_cnt_o, tgt);
  endtask

  task automatic wait_ch3_valid(input int budget, input string tag);
    int i;
    i = 0;
    while (!(sample_valid_o && sample_ch_o == 3'd3) && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    chk_eq(tag, sample_valid_o && sample_ch_o == 3'd3, 1'b1);
  endtask

  initial begin
    int cnt, i, s0, c0, o0;
    logic [15:0] f0;

    reset_i      = 1'b1;
    en_i         = 1'b0;
    period_i     = 24'd200;
    os_sel_i     = 3'b010;
    fifo_afull_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_eq("rst_convst", adc_convst_o, 1'b1);
    chk_eq("rst_cs", adc_cs_o, 1'b1);
    chk_eq("rst_rd", adc_rd_o, 1'b1);
    chk_eq("rst_adc_reset", adc_reset_o, 1'b0);
    chk_eq("rst_valid", sample_valid_o, 1'b0);
    chk_eq("rst_timeout", timeout_o, 1'b0);
    chk_eq("rst_counters", {frame_cnt_o, drop_cnt_o | overrun_cnt_o}, 32'd0);
    chk_eq("rst_os", adc_os_o, 3'd0);
    chk_eq("rst_sample", {13'd0, sample_ch_o, sample_o}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // bring-up
    en_i = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (adc_reset_o) cnt++;
    end
    chk_eq("adc_reset_len", cnt, 4);
    chk_eq("os_latched", adc_os_o, 3'd2);
    chk_eq("bringup_counters", {frame_cnt_o, drop_cnt_o | overrun_cnt_o}, 32'd0);
    os_sel_i = 3'b111;

    // nominal capture
    wait_frames(5, 1400, "nominal_frames");
    chk_eq("frame_cnt_5", frame_cnt_o, 16'd5);
    chk_eq("nominal_samples", n_samp, 40);
    chk_eq("os_held", adc_os_o, 3'd2);
    chk_eq("nominal_overrun", overrun_cnt_o, 16'd0);
    chk_eq("nominal_drop", drop_cnt_o, 16'd0);

    // overrun: 50-cycle period against a ~77-cycle frame gives one overrun per frame
    period_i  = 24'd50;
    data_base = 16'h2000;
    wait_frames(2, 500, "ovr_settle");
    o0 = int'(overrun_cnt_o);
    s0 = n_samp;
    wait_frames(4, 500, "ovr_frames");
    chk_eq("ovr_delta", int'(overrun_cnt_o) - o0, 4);
    chk_eq("ovr_samples", n_samp - s0, 32);
    chk_eq("ovr_drop", drop_cnt_o, 16'd0);

    // backpressure
    period_i  = 24'd200;
    data_base = 16'h3000;
    wait_frames(2, 700, "bp_settle");
    c0 = convst_falls;
    o0 = int'(overrun_cnt_o);
    fifo_afull_i = 1'b1;
    i = 0;
    while (drop_cnt_o != 16'd3 && i < 800) begin
      @(negedge clk_i);
      i++;
    end
    chk_eq("bp_drop_cnt", drop_cnt_o, 16'd3);
    chk_eq("bp_no_convst", convst_falls - c0, 0);
    chk_eq("bp_no_overrun", int'(overrun_cnt_o) - o0, 0);
    fifo_afull_i = 1'b0;
    i = 0;
    while (convst_falls == c0 && i < 250) begin
      @(negedge clk_i);
      i++;
    end
    chk_eq("bp_resume_convst", convst_falls - c0, 1);
    wait_frames(1, 250, "bp_resume_frame");
    chk_eq("bp_drop_final", drop_cnt_o, 16'd3);

    // BUSY timeout
    busy_en = 1'b0;
    s0 = n_samp;
    f0 = frame_cnt_o;
    c0 = convst_falls;
    i = 0;
    while (!timeout_o && i < 400) begin
      @(negedge clk_i);
      i++;
    end
    chk_eq("tmo_set", timeout_o, 1'b1);
    chk_eq("tmo_delay", cyc - last_rise_cyc, 16);
    i = 0;
    while (convst_falls - c0 < 3 && i < 700) begin
      @(negedge clk_i);
      i++;
    end
    chk_eq("tmo_retries", convst_falls - c0, 3);
    chk_eq("tmo_no_samples", n_samp - s0, 0);
    chk_eq("tmo_no_frames", frame_cnt_o, f0);
    chk_eq("tmo_sticky", timeout_o, 1'b1);

    // mid-frame disable
    busy_en   = 1'b1;
    data_base = 16'h4000;
    wait_ch3_valid(400, "dis_reach_ch3");
    en_i = 1'b0;
    wait_frames(1, 100, "dis_frame_done");
    chk_eq("dis_sb_drained", exp_q.size(), 0);
    c0 = convst_falls;
    repeat (450) @(negedge clk_i);
    chk_eq("dis_idle_no_convst", convst_falls - c0, 0);
    chk_eq("dis_idle_cs", adc_cs_o, 1'b1);

    // re-enable with a new oversampling select; status clears
    os_sel_i = 3'b101;
    en_i     = 1'b1;
    repeat (2) @(negedge clk_i);
    chk_eq("reen_os", adc_os_o, 3'd5);
    chk_eq("reen_frame_clr", frame_cnt_o, 16'd0);
    chk_eq("reen_drop_ovr_clr", {drop_cnt_o, overrun_cnt_o}, 32'd0);
    chk_eq("reen_timeout_clr", timeout_o, 1'b0);

    // reset mid-frame during channel 4's read strobe
    data_base = 16'h5000;
    wait_ch3_valid(500, "rst_reach_ch3");
    repeat (2) @(negedge clk_i);
    chk_eq("pre_rst_rd_low", {adc_cs_o, adc_rd_o}, 2'b00);
    reset_i = 1'b1;
    en_i    = 1'b0;
    #1;
    chk_eq("rst_now_cs_rd", {adc_cs_o, adc_rd_o}, 2'b11);
    exp_q.delete();
    s0 = n_samp;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    repeat (100) @(negedge clk_i);
    chk_eq("rst_no_samples", n_samp - s0, 0);
    chk_eq("rst_frame_cnt", frame_cnt_o, 16'd0);
    chk_eq("final_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
